rope_line_drawer: RTL and testbench



---
 rtl/rope_line_drawer.sv | 249 ++++++++++++++++++++++++
 tb/tb_rope_line_drawer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rope_line_drawer.sv
// ---------------------------------------------------------------------------
// rope_line_drawer
//   Render stage for the rope. Once per frame it takes the rope end point,
//   erases the previously drawn rope (background colour) and then draws the
//   new rope as a Bresenham line from a fixed origin, one pixel per clock,
//   into a VGA pixel-write interface.
//
//   Optional feature (macro ROPE_HOOK_EN): after the line, a 3x3 hook block
//   centred on the end point is plotted. The erase pass also removes the
//   previous hook. Without the macro the HOOK state does not exist.
//
// Ports
//   i_clock          system clock
//   i_reset          synchronous, active-high reset
//   i_start          one-cycle draw request (ignored unless idle)
//   i_end_x/i_end_y  rope end point, clamped to the screen on accept
//   o_x/o_y          pixel coordinate (driven straight from registers)
//   o_colour         pixel colour
//   o_plot           pixel write strobe, valid with o_x/o_y/o_colour
//   o_busy           high from the cycle after an accepted start until done
//   o_done           one-cycle pulse when the frame's line is complete
// ---------------------------------------------------------------------------
module rope_line_drawer #(
    parameter int unsigned ORIGIN_X    = 160,
    parameter int unsigned ORIGIN_Y    = 45,
    parameter int unsigned SCREEN_W    = 320,
    parameter int unsigned SCREEN_H    = 240,
    parameter logic [2:0]  ROPE_COLOUR = 3'b111,
    parameter logic [2:0]  BG_COLOUR   = 3'b000
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_start,
    input  logic [9:0] i_end_x,
    input  logic [9:0] i_end_y,
    output logic [8:0] o_x,
    output logic [7:0] o_y,
    output logic [2:0] o_colour,
    output logic       o_plot,
    output logic       o_busy,
    output logic       o_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERASE_INIT,
        S_ERASE_RUN,
        S_DRAW_INIT,
        S_DRAW_RUN,
        S_DONE
`ifdef ROPE_HOOK_EN
        , S_HOOK
`endif
    } state_t;

    localparam logic [9:0] X_MAX = 10'(SCREEN_W - 1);
    localparam logic [9:0] Y_MAX = 10'(SCREEN_H - 1);
    localparam logic [8:0] X0    = 9'(ORIGIN_X);
    localparam logic [7:0] Y0    = 8'(ORIGIN_Y);

    state_t r_state, w_next;

    // Current pixel and current pass target; the origin is always the start.
    logic [8:0] r_cx, r_x1, r_new_x, r_prev_x;
    logic [7:0] r_cy, r_y1, r_new_y, r_prev_y;
    logic       r_prev_valid;
    logic       r_sx_neg, r_sy_neg;
    logic [2:0] r_colour;

    // Bresenham terms: dx >= 0, dy <= 0, err/e2 fit easily in 12 bits.
    logic signed [11:0] r_dx, r_dy, r_err;
    logic signed [11:0] w_e2, w_adx, w_ady;

    logic [8:0] w_tx;
    logic [7:0] w_ty;
    logic       w_init_erase, w_at_end, w_step_x, w_step_y;

`ifdef ROPE_HOOK_EN
    logic       r_erasing;
    logic [1:0] r_hc, r_hr;
    logic [1:0] w_hc_n, w_hr_n;
    logic       w_hook_last;

    // Hook pixel coordinate base-1+off, clamped to [0, lim].
    function automatic logic [9:0] hook_coord(input logic [9:0] base,
                                              input logic [1:0] off,
                                              input logic [9:0] lim);
        logic [9:0] v;
        v = base + {8'b0, off};
        if (v == 10'd0)
            return 10'd0;
        else if ((v - 10'd1) > lim)
            return lim;
        else
            return v - 10'd1;
    endfunction

    assign w_hook_last = (r_hc == 2'd2) && (r_hr == 2'd2);
    assign w_hc_n      = (r_hc == 2'd2) ? 2'd0 : r_hc + 2'd1;
    assign w_hr_n      = (r_hc == 2'd2) ? r_hr + 2'd1 : r_hr;
`endif

    // Target of the pass being initialised: erase the old line, draw the new.
    assign w_init_erase = (r_state == S_ERASE_INIT);
    assign w_tx  = w_init_erase ? r_prev_x : r_new_x;
    assign w_ty  = w_init_erase ? r_prev_y : r_new_y;
    assign w_adx = (w_tx >= X0) ? $signed({3'b0, w_tx - X0}) : $signed({3'b0, X0 - w_tx});
    assign w_ady = (w_ty >= Y0) ? $signed({4'b0, w_ty - Y0}) : $signed({4'b0, Y0 - w_ty});

    assign w_at_end = (r_cx == r_x1) && (r_cy == r_y1);
    assign w_e2     = r_err <<< 1;
    // NOTE: both comparisons use the same e2, so x and y may step in one cycle.
    assign w_step_x = (w_e2 >= r_dy);
    assign w_step_y = (w_e2 <= r_dx);

    assign o_x      = r_cx;
    assign o_y      = r_cy;
    assign o_colour = r_colour;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge i_clock) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    // NOTE: every output of this block gets a default first, so no latches.
    always_comb begin
        w_next = r_state;
        o_plot = 1'b0;
        o_busy = 1'b1;
        o_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_busy = 1'b0;
                if (i_start) w_next = r_prev_valid ? S_ERASE_INIT : S_DRAW_INIT;
            end
            S_ERASE_INIT: w_next = S_ERASE_RUN;
            S_ERASE_RUN: begin
                o_plot = 1'b1;
`ifdef ROPE_HOOK_EN
                if (w_at_end) w_next = S_HOOK;
`else
                if (w_at_end) w_next = S_DRAW_INIT;
`endif
            end
            S_DRAW_INIT: w_next = S_DRAW_RUN;
            S_DRAW_RUN: begin
                o_plot = 1'b1;
`ifdef ROPE_HOOK_EN
                if (w_at_end) w_next = S_HOOK;
`else
                if (w_at_end) w_next = S_DONE;
`endif
            end
`ifdef ROPE_HOOK_EN
            S_HOOK: begin
                o_plot = 1'b1;
                if (w_hook_last) w_next = r_erasing ? S_DRAW_INIT : S_DONE;
            end
`endif
            S_DONE: begin
                o_done = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            // An aborted line is simply forgotten: nothing is marked for erase.
            r_cx         <= '0;
            r_cy         <= '0;
            r_colour     <= '0;
            r_prev_valid <= 1'b0;
            r_x1         <= '0;
            r_y1         <= '0;
            r_new_x      <= '0;
            r_new_y      <= '0;
            r_prev_x     <= '0;
            r_prev_y     <= '0;
            r_sx_neg     <= 1'b0;
            r_sy_neg     <= 1'b0;
            r_dx         <= '0;
            r_dy         <= '0;
            r_err        <= '0;
`ifdef ROPE_HOOK_EN
            r_erasing    <= 1'b0;
            r_hc         <= '0;
            r_hr         <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_new_x <= (i_end_x > X_MAX) ? 9'(X_MAX) : i_end_x[8:0];
                        r_new_y <= (i_end_y > Y_MAX) ? 8'(Y_MAX) : i_end_y[7:0];
                    end
                end
                S_ERASE_INIT, S_DRAW_INIT: begin
                    r_x1     <= w_tx;
                    r_y1     <= w_ty;
                    r_cx     <= X0;
                    r_cy     <= Y0;
                    r_dx     <= w_adx;
                    r_dy     <= -w_ady;
                    r_err    <= w_adx - w_ady;
                    r_sx_neg <= (w_tx < X0);
                    r_sy_neg <= (w_ty < Y0);
                    r_colour <= w_init_erase ? BG_COLOUR : ROPE_COLOUR;
`ifdef ROPE_HOOK_EN
                    r_erasing <= w_init_erase;
                    r_hc      <= '0;
                    r_hr      <= '0;
`endif
                end
                S_ERASE_RUN, S_DRAW_RUN: begin
                    if (w_at_end) begin
`ifdef ROPE_HOOK_EN
                        // Preload the top-left hook pixel so HOOK plots immediately.
                        r_cx <= 9'(hook_coord({1'b0, r_x1}, 2'd0, X_MAX));
                        r_cy <= 8'(hook_coord({2'b0, r_y1}, 2'd0, Y_MAX));
`endif
                    end else begin
                        if (w_step_x) r_cx <= r_sx_neg ? r_cx - 9'd1 : r_cx + 9'd1;
                        if (w_step_y) r_cy <= r_sy_neg ? r_cy - 8'd1 : r_cy + 8'd1;
                        r_err <= r_err + (w_step_x ? r_dy : 12'sd0)
                                       + (w_step_y ? r_dx : 12'sd0);
                    end
                end
`ifdef ROPE_HOOK_EN
                S_HOOK: begin
                    r_hc <= w_hc_n;
                    r_hr <= w_hr_n;
                    r_cx <= 9'(hook_coord({1'b0, r_x1}, w_hc_n, X_MAX));
                    r_cy <= 8'(hook_coord({2'b0, r_y1}, w_hr_n, Y_MAX));
                end
`endif
                S_DONE: begin
                    r_prev_x     <= r_new_x;
                    r_prev_y     <= r_new_y;
                    r_prev_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rope_line_drawer.sv
// ---------------------------------------------------------------------------
// tb_rope_line_drawer
//   Self-checking bench for rope_line_drawer. An integer reference model
//   builds the expected pixel stream (erase of the previous rope, then the
//   new rope, plus hooks when ROPE_HOOK_EN is defined) and the expected
//   start->done cycle count. Directed vectors come from a table; abort,
//   ignored-start and random end points are exercised afterwards.
// ---------------------------------------------------------------------------
module tb_rope_line_drawer;

    localparam int OX = 160;
    localparam int OY = 45;
    localparam int XM = 319;
    localparam int YM = 239;
`ifdef ROPE_HOOK_EN
    localparam int HOOK_N = 9;
`else
    localparam int HOOK_N = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [9:0] end_x = '0;
    logic [9:0] end_y = '0;
    logic [8:0] o_x;
    logic [7:0] o_y;
    logic [2:0] o_colour;
    logic       o_plot, o_busy, o_done;

    rope_line_drawer dut (
        .i_clock  (clk),
        .i_reset  (rst),
        .i_start  (start),
        .i_end_x  (end_x),
        .i_end_y  (end_y),
        .o_x      (o_x),
        .o_y      (o_y),
        .o_colour (o_colour),
        .o_plot   (o_plot),
        .o_busy   (o_busy),
        .o_done   (o_done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int x;
        int y;
        int c;
    } pix_t;

    typedef struct {
        int ex;
        int ey;
        int n_line;
        int lx;
        int ly;
    } vec_t;

    pix_t exp_q[$];
    pix_t got_q[$];

    int m_prev_x = 0;
    int m_prev_y = 0;
    bit m_prev_valid = 1'b0;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    function automatic int clampi(input int v, input int hi);
        if (v < 0)  return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    // Reference line: integer Bresenham from the origin, one entry per pixel.
    function automatic void add_line(input int x1, input int y1, input int c);
        int x, y, dx, dy, sx, sy, err, e2;
        pix_t p;
        x  = OX;
        y  = OY;
        dx = (x1 > x) ? x1 - x : x - x1;
        dy = (y1 > y) ? -(y1 - y) : -(y - y1);
        sx = (x1 >= x) ? 1 : -1;
        sy = (y1 >= y) ? 1 : -1;
        err = dx + dy;
        forever begin
            p.x = x; p.y = y; p.c = c;
            exp_q.push_back(p);
            if (x == x1 && y == y1) break;
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; x += sx; end
            if (e2 <= dx) begin err += dx; y += sy; end
        end
    endfunction

    function automatic void add_hook(input int cx, input int cy, input int c);
        pix_t p;
        for (int r = 0; r < 3; r++)
            for (int k = 0; k < 3; k++) begin
                p.x = clampi(cx - 1 + k, XM);
                p.y = clampi(cy - 1 + r, YM);
                p.c = c;
                exp_q.push_back(p);
            end
    endfunction

    // One frame: model, stimulus, capture, compare. With inject set, a second
    // start pulse arrives mid-frame and must be ignored.
    task automatic do_frame(input int ex, input int ey, input bit inject);
        int   cx, cy, n_inits, exp_cyc, cyc, dones, busy_bad, first_bad, extra;
        bit   seen;
        pix_t p;
        cx = clampi(ex, XM);
        cy = clampi(ey, YM);
        exp_q.delete();
        got_q.delete();
        n_inits = 1;
        if (m_prev_valid) begin
            add_line(m_prev_x, m_prev_y, 0);
            if (HOOK_N > 0) add_hook(m_prev_x, m_prev_y, 0);
            n_inits = 2;
        end
        add_line(cx, cy, 7);
        if (HOOK_N > 0) add_hook(cx, cy, 7);
        exp_cyc = exp_q.size() + n_inits + 1;

        @(negedge clk);
        end_x = 10'(ex);
        end_y = 10'(ey);
        start = 1'b1;
        cyc = 0; dones = 0; busy_bad = 0; seen = 1'b0;
        while (!seen && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) start = 1'b0;
            if (inject && cyc == 4) begin start = 1'b1; end_x = 10'd0; end_y = 10'd0; end
            if (inject && cyc == 5) start = 1'b0;
            if (!o_busy) busy_bad++;
            if (o_plot) begin
                p.x = int'(o_x); p.y = int'(o_y); p.c = int'(o_colour);
                got_q.push_back(p);
            end
            if (o_done) begin dones++; seen = 1'b1; end
        end
        start = 1'b0;
        check("done_seen", int'(seen), 1);
        check("latency", cyc, exp_cyc);
        check("busy_during", busy_bad, 0);
        check("npix", got_q.size(), exp_q.size());
        first_bad = -1;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            if (first_bad < 0 && got_q[i] != exp_q[i]) begin
                first_bad = i;
                $display("pixel %0d: got (%0d,%0d,c%0d) want (%0d,%0d,c%0d)", i,
                         got_q[i].x, got_q[i].y, got_q[i].c,
                         exp_q[i].x, exp_q[i].y, exp_q[i].c);
            end
        end
        check("pix_seq", first_bad, -1);

        // Afterwards the block must sit idle: no busy, no plot, no repeat done.
        extra = 0;
        repeat (3) begin
            @(negedge clk);
            if (o_busy || o_plot || o_done) extra++;
        end
        check("idle_after", extra, 0);
        check("single_done", dones, 1);

        m_prev_x = cx;
        m_prev_y = cy;
        m_prev_valid = 1'b1;
    endtask

    initial begin
        vec_t tbl[4];
        int   n_rope, n_line, lx, ly, seen_cnt, cyc;

        tbl[0] = '{180,  45,  21, 180,  45};
        tbl[1] = '{160,  65,  21, 160,  65};
        tbl[2] = '{150,  55,  11, 150,  55};
        tbl[3] = '{400, 300, 195, 319, 239};

        // Reset state.
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_x", int'(o_x), 0);
        check("rst_y", int'(o_y), 0);
        check("rst_colour", int'(o_colour), 0);
        check("rst_plot", int'(o_plot), 0);
        check("rst_busy", int'(o_busy), 0);
        check("rst_done", int'(o_done), 0);
        rst = 1'b0;

        // Directed vectors.
        for (int i = 0; i < 4; i++) begin
            do_frame(tbl[i].ex, tbl[i].ey, 1'b0);
            n_rope = 0;
            foreach (got_q[j]) if (got_q[j].c == 7) n_rope++;
            n_line = n_rope - HOOK_N;
            check("line_len", n_line, tbl[i].n_line);
            lx = -1; ly = -1;
            n_rope = 0;
            foreach (got_q[j]) begin
                if (got_q[j].c == 7) begin
                    n_rope++;
                    if (n_rope == n_line) begin lx = got_q[j].x; ly = got_q[j].y; end
                end
            end
            check("last_x", lx, tbl[i].lx);
            check("last_y", ly, tbl[i].ly);
        end

        // Start pulse while busy is dropped, not queued.
        do_frame(180, 45, 1'b1);

        // Reset during the draw pass aborts at once and forgets the line.
        @(negedge clk);
        end_x = 10'd160;
        end_y = 10'd65;
        start = 1'b1;
        seen_cnt = 0;
        cyc = 0;
        while (seen_cnt < 5 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) start = 1'b0;
            if (o_plot && o_colour == 3'b111) seen_cnt++;
        end
        start = 1'b0;
        check("abort_reach", seen_cnt, 5);
        rst = 1'b1;
        @(negedge clk);
        check("abort_plot", int'(o_plot), 0);
        check("abort_busy", int'(o_busy), 0);
        check("abort_done", int'(o_done), 0);
        check("abort_colour", int'(o_colour), 0);
        rst = 1'b0;
        m_prev_valid = 1'b0;
        // First frame after the abort: model expects no erase pass.
        do_frame(150, 55, 1'b0);

        // Random end points, including out-of-range values that must clamp.
        for (int i = 0; i < 15; i++)
            do_frame(int'($urandom_range(0, 420)), int'($urandom_range(0, 320)), 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
